// File: rtl/pq_cmd_seq.sv
// Command sequencer: buffers front-panel REPLACE/DEQ requests and issues them one at a
// time to the priority queue device port, capturing results and counting drops.
module pq_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int KVW   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  input  logic           cmd_op,
  input  logic [KVW-1:0] cmd_kv,
  output logic           cmd_ready,
  output logic           pq_replace,
  output logic           pq_deq,
  output logic [KVW-1:0] pq_kvi,
  input  logic           pq_busy,
  input  logic           pq_empty,
  input  logic [KVW-1:0] pq_kvo,
  output logic           res_valid,
  output logic [KVW-1:0] res_kv,
  output logic [7:0]     drop_cnt,
  output logic [15:0]    op_cnt,
  output logic [1:0]     fsm_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  // Handshake: a request transfers on the rising edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on registered occupancy, never on a same-cycle pop.
  logic [KVW:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [KVW:0]  head;

  logic [1:0]    state;
  logic          issue_op;
  logic          empty_at_issue;

  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign pop        = (state == ISSUE);
  assign head       = mem[rd_ptr];
  assign fsm_state  = state;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_op, cmd_kv};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pulses and pq_kvi are launched on the edge entering ISSUE so they are registered
  // and visible for the whole ISSUE cycle; pq_empty cannot change while the queue is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      issue_op       <= 1'b0;
      empty_at_issue <= 1'b0;
      pq_replace     <= 1'b0;
      pq_deq         <= 1'b0;
      pq_kvi         <= '0;
      res_valid      <= 1'b0;
      res_kv         <= '0;
      drop_cnt       <= '0;
      op_cnt         <= '0;
    end else begin
      pq_replace <= 1'b0;
      pq_deq     <= 1'b0;
      res_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty && !pq_busy) begin
            state          <= ISSUE;
            issue_op       <= head[KVW];
            empty_at_issue <= pq_empty;
            if (head[KVW]) begin
              pq_replace <= 1'b1;
              pq_kvi     <= head[KVW-1:0];
            end else begin
              pq_deq <= !pq_empty;
            end
          end
        end
        ISSUE: begin
          if (!issue_op && empty_at_issue) begin
            if (drop_cnt != 8'hFF) begin
              drop_cnt <= drop_cnt + 8'd1;
            end
            state <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!pq_busy) begin
            op_cnt <= op_cnt + 16'd1;
            // A REPLACE into an empty queue has no meaningful top to report.
            if (!empty_at_issue) begin
              res_kv    <= pq_kvo;
              res_valid <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
